// File: rtl/top_level_pkg.sv
// Shared constants and helpers for the four-lane parallel adder array.
package top_level_pkg;

    localparam int DATA_W         = 8;
    localparam int SUM_W          = DATA_W + 1;
    localparam int LANES          = 4;
    localparam int PAIRS_PER_LANE = 3;

    // Index of each adder pair within a lane: g = a+b, h = c+d, i = e+f.
    typedef enum logic [1:0] {
        PAIR_G = 2'd0,
        PAIR_H = 2'd1,
        PAIR_I = 2'd2
    } pair_e;

    // Zero-extending add at the package width; the carry lands in the MSB.
    function automatic logic [SUM_W-1:0] zext_add(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y
    );
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage

// File: rtl/top_level_if.sv
// Operand/result bundle between the upstream stage, the adder array and
// the downstream consumer. The slave side is the adder array.
interface top_level_if
    import top_level_pkg::*;
#(
    parameter int DATA_W = top_level_pkg::DATA_W
);

    logic              in_valid;
    logic [DATA_W-1:0] a1, a2, a3, a4;
    logic [DATA_W-1:0] b1, b2, b3, b4;
    logic [DATA_W-1:0] c1, c2, c3, c4;
    logic [DATA_W-1:0] d1, d2, d3, d4;
    logic [DATA_W-1:0] e1, e2, e3, e4;
    logic [DATA_W-1:0] f1, f2, f3, f4;

    logic              out_valid;
    logic [DATA_W:0]   g1, g2, g3, g4;
    logic [DATA_W:0]   h1, h2, h3, h4;
    logic [DATA_W:0]   i1, i2, i3, i4;

    // Upstream producer / downstream consumer view.
    modport master (
        output in_valid,
        output a1, a2, a3, a4, b1, b2, b3, b4,
        output c1, c2, c3, c4, d1, d2, d3, d4,
        output e1, e2, e3, e4, f1, f2, f3, f4,
        input  out_valid,
        input  g1, g2, g3, g4, h1, h2, h3, h4,
        input  i1, i2, i3, i4
    );

    // Adder array view.
    modport slave (
        input  in_valid,
        input  a1, a2, a3, a4, b1, b2, b3, b4,
        input  c1, c2, c3, c4, d1, d2, d3, d4,
        input  e1, e2, e3, e4, f1, f2, f3, f4,
        output out_valid,
        output g1, g2, g3, g4, h1, h2, h3, h4,
        output i1, i2, i3, i4
    );

endinterface

// File: rtl/add_reg.sv
// One zero-extending adder feeding an enable-gated output register with
// synchronous active-low reset. The carry is kept, so the sum never wraps.
module add_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W:0]   s
);

    logic [DATA_W:0] sum_next;

    // Widen both operands before adding so the carry out lands in the MSB.
    always_comb begin
        sum_next = {1'b0, x} + {1'b0, y};
    end

    // Register the sum only when enabled; operands are ignored otherwise,
    // so junk on x/y while idle never reaches s.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s <= '0;
        end else if (en) begin
            s <= sum_next;
        end
    end

endmodule

// File: rtl/top_level_module.sv
// Four-lane array of twelve independent registered adders. Each lane holds
// the pairs g = a+b, h = c+d, i = e+f; results appear one clock after a
// valid operand set, with a registered copy of the valid strobe.
module top_level_module #(
    parameter int DATA_W = top_level_pkg::DATA_W
) (
    input  logic      clk,
    input  logic      rst_n,
    top_level_if.slave bus
);

    import top_level_pkg::*;

    logic [DATA_W-1:0] op_l [LANES][PAIRS_PER_LANE];
    logic [DATA_W-1:0] op_r [LANES][PAIRS_PER_LANE];
    logic [DATA_W:0]   sum  [LANES][PAIRS_PER_LANE];
    logic              valid_reg;

    // Gather the flat operand names into lane/pair arrays.
    assign op_l[0][PAIR_G] = bus.a1;  assign op_r[0][PAIR_G] = bus.b1;
    assign op_l[1][PAIR_G] = bus.a2;  assign op_r[1][PAIR_G] = bus.b2;
    assign op_l[2][PAIR_G] = bus.a3;  assign op_r[2][PAIR_G] = bus.b3;
    assign op_l[3][PAIR_G] = bus.a4;  assign op_r[3][PAIR_G] = bus.b4;

    assign op_l[0][PAIR_H] = bus.c1;  assign op_r[0][PAIR_H] = bus.d1;
    assign op_l[1][PAIR_H] = bus.c2;  assign op_r[1][PAIR_H] = bus.d2;
    assign op_l[2][PAIR_H] = bus.c3;  assign op_r[2][PAIR_H] = bus.d3;
    assign op_l[3][PAIR_H] = bus.c4;  assign op_r[3][PAIR_H] = bus.d4;

    assign op_l[0][PAIR_I] = bus.e1;  assign op_r[0][PAIR_I] = bus.f1;
    assign op_l[1][PAIR_I] = bus.e2;  assign op_r[1][PAIR_I] = bus.f2;
    assign op_l[2][PAIR_I] = bus.e3;  assign op_r[2][PAIR_I] = bus.f3;
    assign op_l[3][PAIR_I] = bus.e4;  assign op_r[3][PAIR_I] = bus.f4;

    // Twelve adders, all enabled by the same strobe so a set is captured
    // atomically; lanes and pairs never share logic.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            for (genvar gj = 0; gj < PAIRS_PER_LANE; gj++) begin : g_pair
                add_reg #(
                    .DATA_W (DATA_W)
                ) u_add (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (bus.in_valid),
                    .x     (op_l[gi][gj]),
                    .y     (op_r[gi][gj]),
                    .s     (sum[gi][gj])
                );
            end
        end
    endgenerate

    // out_valid tracks in_valid with one cycle of delay; reset wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= bus.in_valid;
        end
    end

    assign bus.out_valid = valid_reg;

    // Scatter the registered sums back onto the flat result names.
    assign bus.g1 = sum[0][PAIR_G];
    assign bus.g2 = sum[1][PAIR_G];
    assign bus.g3 = sum[2][PAIR_G];
    assign bus.g4 = sum[3][PAIR_G];

    assign bus.h1 = sum[0][PAIR_H];
    assign bus.h2 = sum[1][PAIR_H];
    assign bus.h3 = sum[2][PAIR_H];
    assign bus.h4 = sum[3][PAIR_H];

    assign bus.i1 = sum[0][PAIR_I];
    assign bus.i2 = sum[1][PAIR_I];
    assign bus.i3 = sum[2][PAIR_I];
    assign bus.i4 = sum[3][PAIR_I];

endmodule

// File: tb/tb_top_level_module.sv
// Directed-vector bench for the four-lane adder array. Expected sums are
// hand-computed constants.
module tb_top_level_module;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    int op_a [4], op_b [4], op_c [4], op_d [4], op_e [4], op_f [4];
    int exp_g [4], exp_h [4], exp_i [4];

    top_level_if #(.DATA_W(8)) bus ();

    top_level_module #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_val);
        vectors++;
        if (obs !== exp_val) begin
            miscompares++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_val);
        end
    endtask

    // Drive the operand arrays and valid strobe onto the bus.
    task automatic apply(input logic valid);
        bus.in_valid = valid;
        bus.a1 = 8'(op_a[0]); bus.a2 = 8'(op_a[1]); bus.a3 = 8'(op_a[2]); bus.a4 = 8'(op_a[3]);
        bus.b1 = 8'(op_b[0]); bus.b2 = 8'(op_b[1]); bus.b3 = 8'(op_b[2]); bus.b4 = 8'(op_b[3]);
        bus.c1 = 8'(op_c[0]); bus.c2 = 8'(op_c[1]); bus.c3 = 8'(op_c[2]); bus.c4 = 8'(op_c[3]);
        bus.d1 = 8'(op_d[0]); bus.d2 = 8'(op_d[1]); bus.d3 = 8'(op_d[2]); bus.d4 = 8'(op_d[3]);
        bus.e1 = 8'(op_e[0]); bus.e2 = 8'(op_e[1]); bus.e3 = 8'(op_e[2]); bus.e4 = 8'(op_e[3]);
        bus.f1 = 8'(op_f[0]); bus.f2 = 8'(op_f[1]); bus.f3 = 8'(op_f[2]); bus.f4 = 8'(op_f[3]);
    endtask

    task automatic randomize_ops();
        for (int k = 0; k < 4; k++) begin
            op_a[k] = int'($urandom_range(0, 255));
            op_b[k] = int'($urandom_range(0, 255));
            op_c[k] = int'($urandom_range(0, 255));
            op_d[k] = int'($urandom_range(0, 255));
            op_e[k] = int'($urandom_range(0, 255));
            op_f[k] = int'($urandom_range(0, 255));
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all twelve sums and out_valid against the expected arrays.
    task automatic check_all(input string tag, input int exp_v);
        int obs_g [4], obs_h [4], obs_i [4];
        obs_g[0] = int'(bus.g1); obs_g[1] = int'(bus.g2); obs_g[2] = int'(bus.g3); obs_g[3] = int'(bus.g4);
        obs_h[0] = int'(bus.h1); obs_h[1] = int'(bus.h2); obs_h[2] = int'(bus.h3); obs_h[3] = int'(bus.h4);
        obs_i[0] = int'(bus.i1); obs_i[1] = int'(bus.i2); obs_i[2] = int'(bus.i3); obs_i[3] = int'(bus.i4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s g%0d", tag, k + 1), obs_g[k], exp_g[k]);
            check($sformatf("%s h%0d", tag, k + 1), obs_h[k], exp_h[k]);
            check($sformatf("%s i%0d", tag, k + 1), obs_i[k], exp_i[k]);
        end
        check($sformatf("%s out_valid", tag), int'(bus.out_valid), exp_v);
        $display("vector %s: g=%0d,%0d,%0d,%0d h=%0d,%0d,%0d,%0d i=%0d,%0d,%0d,%0d v=%0d",
                 tag, obs_g[0], obs_g[1], obs_g[2], obs_g[3], obs_h[0], obs_h[1], obs_h[2], obs_h[3],
                 obs_i[0], obs_i[1], obs_i[2], obs_i[3], bus.out_valid);
    endtask

    task automatic load_set1();
        op_a = '{2, 4, 6, 8}; op_b = '{1, 2, 3, 4};
        op_c = '{3, 5, 7, 9}; op_d = '{2, 4, 6, 8};
        op_e = '{1, 3, 5, 7}; op_f = '{2, 4, 6, 8};
    endtask

    task automatic expect_set1();
        exp_g = '{3, 6, 9, 12}; exp_h = '{5, 9, 13, 17}; exp_i = '{3, 7, 11, 15};
    endtask

    task automatic expect_zero();
        exp_g = '{0, 0, 0, 0}; exp_h = '{0, 0, 0, 0}; exp_i = '{0, 0, 0, 0};
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset held three cycles with live operands and in_valid=1.
        rst_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            randomize_ops();
            apply(1'b1);
            tick();
        end
        expect_zero();
        check_all("reset", 0);

        // Set 1 then set 2 back to back.
        rst_n = 1'b1;
        load_set1();
        apply(1'b1);
        tick();
        expect_set1();
        check_all("set1", 1);

        op_a = '{3, 5, 7, 9}; op_b = '{2, 1, 2, 3};
        op_c = '{4, 6, 8, 8}; op_d = '{1, 3, 5, 7};
        op_e = '{2, 4, 6, 8}; op_f = '{2, 3, 5, 7};
        apply(1'b1);
        tick();
        exp_g = '{5, 6, 9, 12}; exp_h = '{5, 9, 13, 15}; exp_i = '{4, 7, 11, 15};
        check_all("set2", 1);

        // Set 1 again, then five idle cycles with changing operands.
        load_set1();
        apply(1'b1);
        tick();
        expect_set1();
        check_all("set1b", 1);
        for (int n = 0; n < 5; n++) begin
            randomize_ops();
            apply(1'b0);
            tick();
            check_all($sformatf("hold%0d", n), 0);
        end

        // Carry: every operand at full scale.
        op_a = '{255, 255, 255, 255}; op_b = op_a; op_c = op_a;
        op_d = op_a; op_e = op_a; op_f = op_a;
        apply(1'b1);
        tick();
        exp_g = '{510, 510, 510, 510}; exp_h = exp_g; exp_i = exp_g;
        check_all("carry_max", 1);

        // Mixed boundary cases spread across lanes and pairs.
        op_a = '{255, 1, 0, 128};   op_b = '{1, 255, 0, 128};
        op_c = '{255, 0, 200, 17};  op_d = '{255, 0, 56, 3};
        op_e = '{0, 255, 100, 254}; op_f = '{0, 0, 99, 1};
        apply(1'b1);
        tick();
        exp_g = '{256, 256, 0, 256};
        exp_h = '{510, 0, 256, 20};
        exp_i = '{0, 255, 199, 255};
        check_all("mixed", 1);

        // Reset in the same cycle as a valid set discards it.
        load_set1();
        apply(1'b1);
        rst_n = 1'b0;
        tick();
        expect_zero();
        check_all("rst_mid", 0);

        // First valid set after release lands one cycle later.
        rst_n = 1'b1;
        op_a = '{10, 20, 30, 40};   op_b = '{5, 6, 7, 8};
        op_c = '{100, 0, 1, 250};   op_d = '{100, 0, 2, 10};
        op_e = '{128, 64, 32, 16};  op_f = '{127, 64, 33, 17};
        apply(1'b1);
        tick();
        exp_g = '{15, 26, 37, 48};
        exp_h = '{200, 0, 3, 260};
        exp_i = '{255, 128, 65, 33};
        check_all("post_rst", 1);

        apply(1'b0);
        tick();
        check_all("post_idle", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/top_level_module.md
# top_level_module

Four-lane parallel 8-bit adder array that produces twelve independent unsigned sums per clock. Each lane carries three adder pairs, g = a + b, h = c + d and i = e + f, and the results are registered. The block is a datapath leaf: an upstream stage presents 24 operands with a valid strobe, and a downstream stage consumes 12 carry-preserving sums one cycle later.

## Interface
Parameters:
- DATA_W, default 8: operand width. Sum width is DATA_W+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands on a*..f* are valid this cycle.
- a1, a2, a3, a4  input  DATA_W each  left operands of the g adders, lanes 1–4.
- b1, b2, b3, b4  input  DATA_W each  right operands of the g adders.
- c1, c2, c3, c4  input  DATA_W each  left operands of the h adders.
- d1, d2, d3, d4  input  DATA_W each  right operands of the h adders.
- e1, e2, e3, e4  input  DATA_W each  left operands of the i adders.
- f1, f2, f3, f4  input  DATA_W each  right operands of the i adders.
- out_valid  output  1  g/h/i hold a freshly computed result.
- g1, g2, g3, g4  output  DATA_W+1 each  registered a_k + b_k.
- h1, h2, h3, h4  output  DATA_W+1 each  registered c_k + d_k.
- i1, i2, i3, i4  output  DATA_W+1 each  registered e_k + f_k.

## Operation
- Adders: for k in 1..4, g_k = a_k + b_k, h_k = c_k + d_k, i_k = e_k + f_k.
- Arithmetic is unsigned. Operands are zero-extended to DATA_W+1 before adding.
- Carry out is kept in the MSB, so no overflow or saturation is possible. Maximum result is 2·(2^DATA_W−1), which is 510 for DATA_W=8.
- All twelve adders are independent and compute in parallel. No lane or pair interacts with another.
- Capture: when in_valid=1, all twelve sums are registered together.
- Hold: when in_valid=0, the output registers keep their previous values.
  - Input changes while in_valid=0 have no effect on the outputs.
  - X/undriven operands with in_valid=0 must not propagate to the outputs.
- out_valid is a registered copy of in_valid.
- No backpressure. Downstream must accept every out_valid pulse.

## Timing
- Latency is exactly 1 clock. Operands sampled at edge N with in_valid=1 appear on g/h/i at edge N, and out_valid=1 from edge N until edge N+1.
- Throughput is one operand set per clock. Back-to-back in_valid pulses produce back-to-back results.
- Reset:
  - When rst_n=0 at a rising edge, all twelve sum outputs become 0 and out_valid becomes 0.
  - Reset overrides in_valid in the same cycle.
  - Reset asserted mid-stream discards the in-flight set.
- After rst_n returns to 1, the first in_valid produces a result one cycle later. No extra warm-up cycles.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package top_level_pkg holds:
  - DATA_W = 8
  - SUM_W = DATA_W+1
  - LANES = 4
  - PAIRS_PER_LANE = 3
- Natural sub-module: add_reg.
  - One DATA_W-bit zero-extending adder with an enable-gated, sync active-low-reset output register.
  - Ports: clk, rst_n, en, x, y, s.
  - Instantiated 12 times.
- The valid register lives in the top level.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random operands and in_valid=1 → all g/h/i = 0, out_valid = 0.
- Set 1: in_valid=1 for one cycle with
  - a=2,4,6,8; b=1,2,3,4; c=3,5,7,9; d=2,4,6,8; e=1,3,5,7; f=2,4,6,8
  - → next cycle g=3,6,9,12; h=5,9,13,17; i=3,7,11,15; out_valid=1 for one cycle.
- Set 2 back-to-back with set 1:
  - a=3,5,7,9; b=2,1,2,3; c=4,6,8,8; d=1,3,5,7; e=2,4,6,8; f=2,3,5,7
  - → g=5,6,9,12; h=5,9,13,15; i=4,7,11,15 on consecutive cycles after set 1.
- Carry: all operands 255 → every output 510. Mixed 255+1 → 256. 0+0 → 0.
- Hold: after set 1, change all operands with in_valid=0 for 5 cycles → outputs unchanged at set-1 values, out_valid=0.
- Reset mid-stream: in_valid=1 and rst_n=0 in the same cycle → outputs 0 next cycle, out_valid=0. The next valid set after release is correct.
